// File: rtl/flopr_pipe_rv_if.sv
// flopr_pipe_rv_if: producer/consumer valid-ready bundle for flopr_pipe_rv.
interface flopr_pipe_rv_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
);
   logic                         InValid, InReady, OutValid, OutReady;
   logic [WIDTH-1:0]             InData, OutData;
   logic [$clog2(DEPTH+1)-1:0]   Count;
   modport master (output InValid, InData, OutReady, input InReady, OutValid, OutData, Count);
   modport slave  (input InValid, InData, OutReady, output InReady, OutValid, OutData, Count);
endinterface

// File: rtl/flopr_pipe_rv.sv
// flopr_pipe_rv: DEPTH-stage valid/ready register chain with bubble collapse and flush.
module flopr_pipe_rv #(
   parameter int               WIDTH    = 8,
   parameter int               DEPTH    = 2,
   parameter logic [WIDTH-1:0] RESETVAL = '0
) (
   input logic            clk,
   input logic            reset,
   input logic            clear,
   flopr_pipe_rv_if.slave p
);
   localparam int CW = $clog2(DEPTH + 1);
   if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
      $error("flopr_pipe_rv: DEPTH must be 1..16");
   end
   logic [DEPTH-1:0] v, adv;
   logic [WIDTH-1:0] d [DEPTH];
   logic [CW-1:0]    cnt;
   logic             flush, acc;
   // Ready ripples from the consumer back to the producer so a full pipe still streams.
   always_comb begin
      logic a;
      a = v[DEPTH-1] & p.OutReady;
      adv[DEPTH-1] = a;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         a = v[i] & (~v[i+1] | a);
         adv[i] = a;
      end
   end
   always_comb begin
      cnt = '0;
      for (int i = 0; i < DEPTH; i++) cnt = cnt + CW'(v[i]);
   end
   assign flush      = reset | clear;
   assign p.InReady  = (~v[0] | adv[0]) & ~flush;
   assign acc        = p.InValid & p.InReady;
   assign p.OutValid = v[DEPTH-1];
   assign p.OutData  = d[DEPTH-1];
   assign p.Count    = cnt;
   always_ff @(posedge clk)
      if (flush) begin
         v <= '0;
         for (int i = 0; i < DEPTH; i++) d[i] <= RESETVAL;
      end else begin
         if (acc) begin
            d[0] <= p.InData;
            v[0] <= 1'b1;
         end else if (adv[0]) v[0] <= 1'b0;
         for (int i = 1; i < DEPTH; i++)
            if (adv[i-1]) begin
               d[i] <= d[i-1];
               v[i] <= 1'b1;
            end else if (adv[i]) v[i] <= 1'b0;
      end
   a_in_stable: assert property (@(posedge clk) disable iff (reset)
      p.InValid && !p.InReady |=> !p.InValid || $stable(p.InData));
   a_count_max: assert property (@(posedge clk) int'(cnt) <= DEPTH);
endmodule

// File: tb/tb_flopr_pipe_rv.sv
// tb_flopr_pipe_rv: vector table on a DEPTH=3 pipe plus a bubble-collapse sequence on DEPTH=4.
module tb_flopr_pipe_rv;
   logic clk = 1'b0;
   logic rst3 = 1'b1, clr3 = 1'b0, rst4 = 1'b1, clr4 = 1'b0;
   int   tests = 0, fails = 0;
   flopr_pipe_rv_if #(.WIDTH(8), .DEPTH(3)) b3 ();
   flopr_pipe_rv_if #(.WIDTH(8), .DEPTH(4)) b4 ();
   flopr_pipe_rv #(.WIDTH(8), .DEPTH(3), .RESETVAL(8'h00)) d3 (.clk(clk), .reset(rst3), .clear(clr3), .p(b3));
   flopr_pipe_rv #(.WIDTH(8), .DEPTH(4), .RESETVAL(8'hC3)) d4 (.clk(clk), .reset(rst4), .clear(clr4), .p(b4));
   always #5 clk = ~clk;
   typedef struct {
      logic       rst, clr, iv;
      logic [7:0] id;
      logic       ordy, ir, ov;
      logic [7:0] od;
      int         cnt;
   } vec_t;
   vec_t tv[$];
   task automatic a(input logic rst, clr, iv, input logic [7:0] id, input logic ordy, ir, ov,
                    input logic [7:0] od, input int cnt);
      tv.push_back('{rst, clr, iv, id, ordy, ir, ov, od, cnt});
   endtask
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   initial begin
      b3.InValid = 0; b3.InData = 0; b3.OutReady = 0;
      b4.InValid = 0; b4.InData = 0; b4.OutReady = 0;
      a(1,0,0,8'h00,0, 0,0,8'h00,0); a(1,0,0,8'h00,0, 0,0,8'h00,0);
      a(0,0,1,8'h11,1, 1,0,8'h00,0); a(0,0,1,8'h22,1, 1,0,8'h00,1);
      a(0,0,1,8'h33,1, 1,0,8'h00,2); a(0,0,0,8'h00,1, 1,1,8'h11,3);
      a(0,0,0,8'h00,1, 1,1,8'h22,2); a(0,0,0,8'h00,1, 1,1,8'h33,1);
      a(0,0,0,8'h00,1, 1,0,8'h33,0);
      a(0,0,1,8'h01,0, 1,0,8'h33,0); a(0,0,1,8'h02,0, 1,0,8'h33,1);
      a(0,0,1,8'h03,0, 1,0,8'h33,2); a(0,0,1,8'h04,0, 0,1,8'h01,3);
      a(0,0,1,8'h04,0, 0,1,8'h01,3); a(0,0,1,8'h04,1, 1,1,8'h01,3);
      a(0,0,0,8'h00,1, 1,1,8'h02,3); a(0,0,0,8'h00,1, 1,1,8'h03,2);
      a(0,0,0,8'h00,1, 1,1,8'h04,1); a(0,0,0,8'h00,1, 1,0,8'h04,0);
      a(0,0,1,8'hA1,0, 1,0,8'h04,0); a(0,0,1,8'hA2,0, 1,0,8'h04,1);
      a(0,0,1,8'hA3,0, 1,0,8'h04,2); a(0,1,1,8'hA4,0, 0,1,8'hA1,3);
      a(0,0,0,8'h00,1, 1,0,8'h00,0); a(0,0,0,8'h00,1, 1,0,8'h00,0);
      a(0,0,0,8'h00,1, 1,0,8'h00,0);
      a(0,0,1,8'hB1,1, 1,0,8'h00,0); a(0,0,0,8'h00,1, 1,0,8'h00,1);
      a(0,0,0,8'h00,1, 1,0,8'h00,1); a(0,1,0,8'h00,1, 0,1,8'hB1,1);
      a(0,0,0,8'h00,1, 1,0,8'h00,0); a(0,0,0,8'h00,1, 1,0,8'h00,0);
      a(0,0,1,8'hC1,1, 1,0,8'h00,0); a(0,0,1,8'hC2,1, 1,0,8'h00,1);
      a(1,0,1,8'hC3,1, 0,0,8'h00,2); a(1,0,0,8'h00,1, 0,0,8'h00,0);
      a(0,0,1,8'h7E,1, 1,0,8'h00,0); a(0,0,0,8'h00,1, 1,0,8'h00,1);
      a(0,0,0,8'h00,1, 1,0,8'h00,1); a(0,0,0,8'h00,1, 1,1,8'h7E,1);
      a(0,0,0,8'h00,1, 1,0,8'h7E,0);
      foreach (tv[k]) begin
         rst3 = tv[k].rst; clr3 = tv[k].clr;
         b3.InValid = tv[k].iv; b3.InData = tv[k].id; b3.OutReady = tv[k].ordy;
         @(negedge clk);
         chk($sformatf("v%0d InReady", k), 32'(b3.InReady), 32'(tv[k].ir));
         chk($sformatf("v%0d OutValid", k), 32'(b3.OutValid), 32'(tv[k].ov));
         if (tv[k].ov || tv[k].rst || (k > 0 && tv[k-1].clr))
            chk($sformatf("v%0d OutData", k), 32'(b3.OutData), 32'(tv[k].od));
         chk($sformatf("v%0d Count", k), 32'(b3.Count), 32'(tv[k].cnt));
         tick();
      end
      // DEPTH=4: reset values with a non-zero RESETVAL, then a lone beat and a packed follower.
      b4.InValid = 1; b4.InData = 8'hA5;
      @(negedge clk);
      chk("d4 reset InReady", 32'(b4.InReady), 0);
      chk("d4 reset OutValid", 32'(b4.OutValid), 0);
      chk("d4 reset OutData", 32'(b4.OutData), 32'h00C3);
      chk("d4 reset Count", 32'(b4.Count), 0);
      tick();
      rst4 = 0;
      @(negedge clk);
      chk("d4 first InReady", 32'(b4.InReady), 1);
      tick();
      b4.InValid = 0;
      tick(); tick();
      @(negedge clk);
      chk("d4 not early OutValid", 32'(b4.OutValid), 0);
      tick();
      b4.InValid = 1; b4.InData = 8'h5A;
      @(negedge clk);
      chk("d4 lat OutValid", 32'(b4.OutValid), 1);
      chk("d4 lat OutData", 32'(b4.OutData), 32'h00A5);
      chk("d4 lat Count", 32'(b4.Count), 1);
      chk("d4 second InReady", 32'(b4.InReady), 1);
      tick();
      b4.InValid = 0;
      tick(); tick();
      @(negedge clk);
      chk("d4 packed Count", 32'(b4.Count), 2);
      chk("d4 packed OutData", 32'(b4.OutData), 32'h00A5);
      tick();
      @(negedge clk);
      chk("d4 stall Count", 32'(b4.Count), 2);
      chk("d4 stall InReady", 32'(b4.InReady), 1);
      b4.OutReady = 1;
      tick();
      @(negedge clk);
      chk("d4 next OutData", 32'(b4.OutData), 32'h005A);
      chk("d4 next Count", 32'(b4.Count), 1);
      tick();
      @(negedge clk);
      chk("d4 drained OutValid", 32'(b4.OutValid), 0);
      chk("d4 drained Count", 32'(b4.Count), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
